// File: rtl/regbank_write_port_pkg.sv
// Shared constants and request type for the 16 x 32-bit register bank.
// The read mux and hazard logic use these definitions too.
package regbank_write_port_pkg;

    localparam int REG_W    = 32;
    localparam int NUM_REGS = 16;
    localparam int SEL_W    = 4;

    // One write-back request: destination register and value.
    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic [REG_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/regbank_write_port_if.sv
// Write-back handshake between the datapath (master) and the register bank write port (slave).
interface regbank_write_port_if
    import regbank_write_port_pkg::*;
#(
    parameter int DATA_W = REG_W,
    parameter int SEL_W  = regbank_write_port_pkg::SEL_W
);
    logic              wr_valid;
    logic              wr_ready;
    logic [SEL_W-1:0]  wr_sel;
    logic [DATA_W-1:0] wr_data;

    modport master (output wr_valid, output wr_sel, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_sel, input wr_data, output wr_ready);
endinterface

// File: rtl/regbank_wr_decode.sv
// Register-select to one-hot decoder with enable; all zeros when disabled.
module regbank_wr_decode #(
    parameter int SEL_W = 4,
    parameter int N     = 16
) (
    input  logic             en_i,
    input  logic [SEL_W-1:0] sel_i,
    output logic [N-1:0]     onehot_o
);
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bit
            assign onehot_o[gi] = en_i && (sel_i == SEL_W'(gi));
        end
    endgenerate
endmodule

// File: rtl/regbank_write_port.sv
// Write side of the register bank: in-order write queue, one commit per cycle,
// and a pending mask of registers that still have queued writes.
module regbank_write_port
    import regbank_write_port_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = REG_W,
    parameter int SEL_W  = regbank_write_port_pkg::SEL_W
) (
    input  logic                 clk,
    input  logic                 rst,
    regbank_write_port_if.slave  wr,
    output logic [DATA_W-1:0]    r0,
    output logic [DATA_W-1:0]    r1,
    output logic [DATA_W-1:0]    r2,
    output logic [DATA_W-1:0]    r3,
    output logic [DATA_W-1:0]    r4,
    output logic [DATA_W-1:0]    r5,
    output logic [DATA_W-1:0]    r6,
    output logic [DATA_W-1:0]    r7,
    output logic [DATA_W-1:0]    r8,
    output logic [DATA_W-1:0]    r9,
    output logic [DATA_W-1:0]    r10,
    output logic [DATA_W-1:0]    r11,
    output logic [DATA_W-1:0]    r12,
    output logic [DATA_W-1:0]    r13,
    output logic [DATA_W-1:0]    r14,
    output logic [DATA_W-1:0]    r15,
    output logic [NUM_REGS-1:0]  pending,
    output logic                 busy
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SLOTS = 1 << PTR_W;   // storage rounded up so any pointer value indexes safely
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [SEL_W-1:0]  q_sel_q  [SLOTS];
    logic [DATA_W-1:0] q_data_q [SLOTS];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    logic                push;
    logic                pop;
    logic [NUM_REGS-1:0] commit_we;
    logic [DEPTH-1:0]    entry_occ;
    logic [NUM_REGS-1:0] entry_mask [DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    // Ready depends only on registered occupancy (and reset), never on valid or the commit.
    assign wr.wr_ready = (count_q < CNT_W'(DEPTH)) && !rst;
    assign push        = wr.wr_valid && wr.wr_ready;
    assign pop         = (count_q != '0);
    assign busy        = (count_q != '0);

    // Pointer and occupancy next-state; a simultaneous push and pop leaves count unchanged.
    always_comb begin
        head_d  = pop  ? ptr_inc(head_q) : head_q;
        tail_d  = push ? ptr_inc(tail_q) : tail_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Queue control state; reset discards every queued entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Queue storage: payload is only meaningful where count says so, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            q_sel_q[tail_q]  <= wr.wr_sel;
            q_data_q[tail_q] <= wr.wr_data;
        end
    end

    regbank_wr_decode #(.SEL_W(SEL_W), .N(NUM_REGS)) u_commit_dec (
        .en_i     (pop),
        .sel_i    (q_sel_q[head_q]),
        .onehot_o (commit_we)
    );

    // Register array: head entry lands in its destination register on each commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (commit_we[i]) begin
                    regs_q[i] <= q_data_q[head_q];
                end
            end
        end
    end

    // Each slot contributes its destination bit while it sits between head and head+count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign entry_occ[gi] = ((gi + DEPTH - int'(head_q)) % DEPTH) < int'(count_q);

            regbank_wr_decode #(.SEL_W(SEL_W), .N(NUM_REGS)) u_pend_dec (
                .en_i     (entry_occ[gi]),
                .sel_i    (q_sel_q[gi]),
                .onehot_o (entry_mask[gi])
            );
        end
    endgenerate

    // Pending mask is the OR of all occupied entries' one-hot destinations.
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pending = pending | entry_mask[i];
        end
    end

    assign r0  = regs_q[0];
    assign r1  = regs_q[1];
    assign r2  = regs_q[2];
    assign r3  = regs_q[3];
    assign r4  = regs_q[4];
    assign r5  = regs_q[5];
    assign r6  = regs_q[6];
    assign r7  = regs_q[7];
    assign r8  = regs_q[8];
    assign r9  = regs_q[9];
    assign r10 = regs_q[10];
    assign r11 = regs_q[11];
    assign r12 = regs_q[12];
    assign r13 = regs_q[13];
    assign r14 = regs_q[14];
    assign r15 = regs_q[15];
endmodule

// File: tb/tb_regbank_write_port.sv
// Bench for regbank_write_port: a DEPTH=2 instance plus a DEPTH=1 instance (to reach the
// full/backpressure case) driven by the same requests, checked against a queue-based model.
module tb_regbank_write_port;
    import regbank_write_port_pkg::*;

    localparam int DEP [2] = '{2, 1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regbank_write_port_if wr0 ();
    regbank_write_port_if wr1 ();

    logic [31:0] rv0 [16];
    logic [31:0] rv1 [16];
    logic [15:0] pend0, pend1;
    logic        busy0, busy1;

    regbank_write_port #(.DEPTH(2)) dut0 (
        .clk(clk), .rst(rst), .wr(wr0),
        .r0(rv0[0]),   .r1(rv0[1]),   .r2(rv0[2]),   .r3(rv0[3]),
        .r4(rv0[4]),   .r5(rv0[5]),   .r6(rv0[6]),   .r7(rv0[7]),
        .r8(rv0[8]),   .r9(rv0[9]),   .r10(rv0[10]), .r11(rv0[11]),
        .r12(rv0[12]), .r13(rv0[13]), .r14(rv0[14]), .r15(rv0[15]),
        .pending(pend0), .busy(busy0)
    );

    regbank_write_port #(.DEPTH(1)) dut1 (
        .clk(clk), .rst(rst), .wr(wr1),
        .r0(rv1[0]),   .r1(rv1[1]),   .r2(rv1[2]),   .r3(rv1[3]),
        .r4(rv1[4]),   .r5(rv1[5]),   .r6(rv1[6]),   .r7(rv1[7]),
        .r8(rv1[8]),   .r9(rv1[9]),   .r10(rv1[10]), .r11(rv1[11]),
        .r12(rv1[12]), .r13(rv1[13]), .r14(rv1[14]), .r15(rv1[15]),
        .pending(pend1), .busy(busy1)
    );

    // Reference model: one FIFO of requests and one register image per instance.
    wr_req_t     mq [2][$];
    logic [31:0] mregs [2][16];
    bit          model_ok = 1'b0;

    logic        cur_v;
    logic [3:0]  cur_s;
    logic [31:0] cur_d;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic v, input logic [3:0] s, input logic [31:0] dv);
        rst   = r;
        cur_v = v;
        cur_s = s;
        cur_d = dv;
        wr0.wr_valid = v; wr0.wr_sel = s; wr0.wr_data = dv;
        wr1.wr_valid = v; wr1.wr_sel = s; wr1.wr_data = dv;
        #1;
    endtask

    task automatic check_model();
        for (int d = 0; d < 2; d++) begin
            logic        exp_ready;
            logic [15:0] exp_pend;
            int          bad;
            logic [31:0] act_r;
            exp_ready = (mq[d].size() < DEP[d]) && !rst;
            exp_pend  = '0;
            foreach (mq[d][k]) exp_pend[mq[d][k].sel] = 1'b1;
            check($sformatf("d%0d ready", d), 32'((d == 0) ? wr0.wr_ready : wr1.wr_ready), 32'(exp_ready));
            check($sformatf("d%0d busy", d), 32'((d == 0) ? busy0 : busy1), 32'(mq[d].size() != 0));
            check($sformatf("d%0d pending", d), 32'((d == 0) ? pend0 : pend1), 32'(exp_pend));
            bad = 0;
            for (int i = 15; i >= 0; i--) begin
                act_r = (d == 0) ? rv0[i] : rv1[i];
                if (act_r !== mregs[d][i]) bad = i;
            end
            act_r = (d == 0) ? rv0[bad] : rv1[bad];
            check($sformatf("d%0d r%0d", d, bad), act_r, mregs[d][bad]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            bit      rdy;
            wr_req_t h;
            wr_req_t req;
            if (rst) begin
                mq[d].delete();
                for (int i = 0; i < 16; i++) mregs[d][i] = '0;
            end else begin
                rdy = (mq[d].size() < DEP[d]);
                if (mq[d].size() > 0) begin
                    h = mq[d].pop_front();
                    mregs[d][h.sel] = h.data;
                end
                if (cur_v && rdy) begin
                    req.sel  = cur_s;
                    req.data = cur_d;
                    mq[d].push_back(req);
                end
            end
        end
        if (rst) model_ok = 1'b1;
        #1;
    endtask

    task automatic step(input logic r, input logic v, input logic [3:0] s, input logic [31:0] dv);
        drive(r, v, s, dv);
        if (model_ok) check_model();
        tick();
    endtask

    typedef struct {
        logic        rst;
        logic        v;
        logic [3:0]  sel;
        logic [31:0] data;
        logic        exp_ready;
        logic        exp_busy;
        logic [15:0] exp_pend;
        logic [3:0]  chk_sel;
        logic [31:0] exp_r;
    } vec_t;

    vec_t vecs [19];

    initial begin
        // rst, v, sel, data, ready, busy, pending, check reg, expected value (seen before the edge)
        vecs[0]  = '{1'b1, 1'b0, 4'd0,  32'h0,        1'b0, 1'b0, 16'h0000, 4'd5,  32'h0};
        vecs[1]  = '{1'b0, 1'b1, 4'd5,  32'hDEADBEEF, 1'b1, 1'b0, 16'h0000, 4'd5,  32'h0};
        vecs[2]  = '{1'b0, 1'b0, 4'd0,  32'h0,        1'b1, 1'b1, 16'h0020, 4'd5,  32'h0};
        vecs[3]  = '{1'b0, 1'b0, 4'd0,  32'h0,        1'b1, 1'b0, 16'h0000, 4'd5,  32'hDEADBEEF};
        vecs[4]  = '{1'b0, 1'b1, 4'd1,  32'd1,        1'b1, 1'b0, 16'h0000, 4'd1,  32'h0};
        vecs[5]  = '{1'b0, 1'b1, 4'd2,  32'd2,        1'b1, 1'b1, 16'h0002, 4'd1,  32'h0};
        vecs[6]  = '{1'b0, 1'b1, 4'd3,  32'd3,        1'b1, 1'b1, 16'h0004, 4'd1,  32'd1};
        vecs[7]  = '{1'b0, 1'b1, 4'd4,  32'd4,        1'b1, 1'b1, 16'h0008, 4'd2,  32'd2};
        vecs[8]  = '{1'b0, 1'b0, 4'd0,  32'h0,        1'b1, 1'b1, 16'h0010, 4'd3,  32'd3};
        vecs[9]  = '{1'b0, 1'b0, 4'd0,  32'h0,        1'b1, 1'b0, 16'h0000, 4'd4,  32'd4};
        vecs[10] = '{1'b0, 1'b1, 4'd7,  32'hAA,       1'b1, 1'b0, 16'h0000, 4'd7,  32'h0};
        vecs[11] = '{1'b0, 1'b1, 4'd7,  32'h55,       1'b1, 1'b1, 16'h0080, 4'd7,  32'h0};
        vecs[12] = '{1'b0, 1'b0, 4'd0,  32'h0,        1'b1, 1'b1, 16'h0080, 4'd7,  32'hAA};
        vecs[13] = '{1'b0, 1'b0, 4'd0,  32'h0,        1'b1, 1'b0, 16'h0000, 4'd7,  32'h55};
        vecs[14] = '{1'b0, 1'b1, 4'd9,  32'd3,        1'b1, 1'b0, 16'h0000, 4'd9,  32'h0};
        vecs[15] = '{1'b1, 1'b1, 4'd10, 32'd4,        1'b0, 1'b1, 16'h0200, 4'd9,  32'h0};
        vecs[16] = '{1'b0, 1'b0, 4'd0,  32'h0,        1'b1, 1'b0, 16'h0000, 4'd9,  32'h0};
        vecs[17] = '{1'b0, 1'b0, 4'd0,  32'h0,        1'b1, 1'b0, 16'h0000, 4'd10, 32'h0};
        vecs[18] = '{1'b0, 1'b0, 4'd0,  32'h0,        1'b1, 1'b0, 16'h0000, 4'd5,  32'h0};

        // Power-up reset; outputs are not defined before the first reset edge.
        drive(1'b1, 1'b0, 4'd0, 32'h0);
        tick();

        // Directed vectors on the DEPTH=2 instance.
        for (int n = 0; n < 19; n++) begin
            $display("vec %0d: rst=%0b valid=%0b sel=%0d data=%h", n, vecs[n].rst, vecs[n].v, vecs[n].sel, vecs[n].data);
            drive(vecs[n].rst, vecs[n].v, vecs[n].sel, vecs[n].data);
            check($sformatf("vec%0d ready", n), 32'(wr0.wr_ready), 32'(vecs[n].exp_ready));
            check($sformatf("vec%0d busy", n), 32'(busy0), 32'(vecs[n].exp_busy));
            check($sformatf("vec%0d pending", n), 32'(pend0), 32'(vecs[n].exp_pend));
            check($sformatf("vec%0d r%0d", n, vecs[n].chk_sel), rv0[vecs[n].chk_sel], vecs[n].exp_r);
            check_model();
            tick();
        end

        // Backpressure on the DEPTH=1 instance: second request must wait one cycle and survive.
        $display("seq full: push sel3, then hold sel6 through backpressure");
        drive(1'b0, 1'b1, 4'd3, 32'h11);
        check("full a ready", 32'(wr1.wr_ready), 32'd1);
        check_model(); tick();
        drive(1'b0, 1'b1, 4'd6, 32'h22);
        check("full b ready", 32'(wr1.wr_ready), 32'd0);
        check("full b pending", 32'(pend1), 32'h0008);
        check_model(); tick();
        drive(1'b0, 1'b1, 4'd6, 32'h22);
        check("full c ready", 32'(wr1.wr_ready), 32'd1);
        check("full c r3", rv1[3], 32'h11);
        check_model(); tick();
        drive(1'b0, 1'b0, 4'd0, 32'h0);
        check("full d busy", 32'(busy1), 32'd1);
        check("full d pending", 32'(pend1), 32'h0040);
        check_model(); tick();
        drive(1'b0, 1'b0, 4'd0, 32'h0);
        check("full e r6", rv1[6], 32'h22);
        check("full e busy", 32'(busy1), 32'd0);
        check_model(); tick();

        // Random traffic with occasional resets, both instances against the model.
        for (int n = 0; n < 600; n++) begin
            logic        r;
            logic        v;
            logic [3:0]  s;
            logic [31:0] dv;
            r  = ($urandom_range(0, 39) == 0);
            v  = ($urandom_range(0, 9) < 6);
            s  = 4'($urandom_range(0, 15));
            dv = $urandom;
            step(r, v, s, dv);
        end
        drive(1'b0, 1'b0, 4'd0, 32'h0);
        check_model();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
